// File: rtl/gpu_blit_pkg.sv
// Shared definitions for the sprite blitter: FSM encoding, default framebuffer
// placement, sprite geometry constants and the window byte selector.
package gpu_blit_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_SPR  = 3'd1,
        S_LOAD_SCR  = 3'd2,
        S_STORE_SCR = 3'd3,
        S_NEXT_ROW  = 3'd4,
        S_CLEAR     = 3'd5
    } state_t;

    localparam int FB_BASE_DEFAULT = 'h100;
    localparam int SPR_ROWS_WIDE   = 16;

    // Screen byte k of a row takes window bits [23-8k -: 8].
    function automatic logic [7:0] window_byte(input logic [23:0] p, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = p[23:16];
            2'd1:    b = p[15:8];
            default: b = p[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gpu_blit_sprite_shifter.sv
// Aligns one sprite row to the pixel offset inside a 24-bit, three screen byte window.
module gpu_blit_sprite_shifter
(
    input  logic [15:0] spr16,
    input  logic        wide,
    input  logic [2:0]  shift,
    output logic [23:0] window
);

    logic [23:0] base;

    // Narrow sprites use only the upper byte; the low byte of spr16 is don't-care.
    always_comb begin
        base   = wide ? {spr16, 8'h00} : {spr16[15:8], 16'h0000};
        window = base >> shift;
    end

endmodule

// File: rtl/gpu_blit.sv
// Sprite blitter: XOR-draws 8xN / 16x16 sprites into a byte-packed framebuffer
// with clip-or-wrap edges and sticky collision, plus a full-screen clear.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for draw/clear; done pulses here after an operation
// S_LOAD_SPR  | fetching the current sprite row (1 byte, or 2 for 16x16)
// S_LOAD_SCR  | reading screen byte k of the current row
// S_STORE_SCR | writing old ^ pattern back to screen byte k
// S_NEXT_ROW  | advancing to the next sprite row or finishing
// S_CLEAR     | writing zero to one framebuffer byte per cycle
module gpu_blit
    import gpu_blit_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int FB_BASE = FB_BASE_DEFAULT,
    parameter int W_BYTES = 8,
    parameter int H       = 32,
    parameter int WRAP    = 0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              draw,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        lines,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_idx,
    input  logic [7:0]        mem_read_byte,
    input  logic              mem_read_ack,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_idx,
    output logic [7:0]        mem_write_byte
);

    localparam int CW  = $clog2(W_BYTES);
    localparam int RW  = $clog2(H);
    localparam int CLW = $clog2(W_BYTES * H);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] spr_ptr;
    logic [7:0]        spr_hi, spr_lo, old_byte;
    logic              spr_idx, wide;
    logic [2:0]        shift;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [4:0]        r_cnt, rows;
    logic [1:0]        k;
    logic [CLW-1:0]    clr_cnt;

    logic              accept_draw, accept_clear;
    logic [1:0]        nbytes, k_next;
    logic [CW:0]       col_sum, col_sum_n;
    logic              next_k_ok, row_last, row_edge;
    logic [ADDR_W-1:0] scr_addr;
    logic [23:0]       window;
    logic [7:0]        pat_k;

    gpu_blit_sprite_shifter u_shifter (
        .spr16  ({spr_hi, spr_lo}),
        .wide   (wide),
        .shift  (shift),
        .window (window)
    );

    // Row/column geometry and the screen address of byte k in the current row.
    always_comb begin
        nbytes    = (wide ? 2'd2 : 2'd1) + ((shift != 3'd0) ? 2'd1 : 2'd0);
        k_next    = k + 2'd1;
        col_sum   = {1'b0, col} + (CW+1)'(k);
        col_sum_n = {1'b0, col} + (CW+1)'(k_next);
        // Columns past the right edge are monotone in k, so one clipped byte ends the row.
        next_k_ok = (k_next < nbytes) && !((WRAP == 0) && col_sum_n[CW]);
        row_last  = (r_cnt + 5'd1) == rows;
        row_edge  = row == RW'(H - 1);
        scr_addr  = ADDR_W'(FB_BASE) + (ADDR_W'(row) << CW) + ADDR_W'(col_sum[CW-1:0]);
        pat_k     = window_byte(window, k);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and the combinational memory interface.
    always_comb begin
        state_d        = state_q;
        accept_draw    = 1'b0;
        accept_clear   = 1'b0;
        mem_read       = 1'b0;
        mem_read_idx   = '0;
        mem_write      = 1'b0;
        mem_write_idx  = '0;
        mem_write_byte = '0;
        case (state_q)
            S_IDLE: begin
                // No accept while done is high so the two never overlap.
                if (!done) begin
                    if (clear) begin
                        accept_clear = 1'b1;
                        state_d      = S_CLEAR;
                    end else if (draw) begin
                        accept_draw = 1'b1;
                        state_d     = S_LOAD_SPR;
                    end
                end
            end
            S_LOAD_SPR: begin
                mem_read     = !mem_read_ack;
                mem_read_idx = spr_ptr;
                if (mem_read_ack && (!wide || spr_idx)) state_d = S_LOAD_SCR;
            end
            S_LOAD_SCR: begin
                mem_read     = !mem_read_ack;
                mem_read_idx = scr_addr;
                if (mem_read_ack) state_d = S_STORE_SCR;
            end
            S_STORE_SCR: begin
                mem_write      = 1'b1;
                mem_write_idx  = scr_addr;
                mem_write_byte = old_byte ^ pat_k;
                state_d        = next_k_ok ? S_LOAD_SCR : S_NEXT_ROW;
            end
            S_NEXT_ROW: begin
                if (row_last || ((WRAP == 0) && row_edge)) state_d = S_IDLE;
                else                                       state_d = S_LOAD_SPR;
            end
            S_CLEAR: begin
                mem_write      = 1'b1;
                mem_write_idx  = ADDR_W'(FB_BASE) + ADDR_W'(clr_cnt);
                mem_write_byte = 8'h00;
                if (clr_cnt == CLW'(W_BYTES * H - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            spr_ptr   <= '0;
            spr_hi    <= '0;
            spr_lo    <= '0;
            old_byte  <= '0;
            spr_idx   <= 1'b0;
            wide      <= 1'b0;
            shift     <= '0;
            col       <= '0;
            row       <= '0;
            r_cnt     <= '0;
            rows      <= '0;
            k         <= '0;
            clr_cnt   <= '0;
        end else begin
            busy <= state_d != S_IDLE;
            done <= (state_q != S_IDLE) && (state_d == S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (accept_draw) begin
                        spr_ptr   <= addr;
                        wide      <= lines == 4'd0;
                        rows      <= (lines == 4'd0) ? 5'(SPR_ROWS_WIDE) : {1'b0, lines};
                        shift     <= x[2:0];
                        col       <= CW'((x % (8 * W_BYTES)) >> 3);
                        row       <= RW'(y % H);
                        r_cnt     <= '0;
                        spr_idx   <= 1'b0;
                        k         <= '0;
                        collision <= 1'b0;
                    end
                    if (accept_clear) clr_cnt <= '0;
                end
                S_LOAD_SPR: begin
                    if (mem_read_ack) begin
                        spr_ptr <= spr_ptr + ADDR_W'(1);
                        if (!spr_idx) spr_hi <= mem_read_byte;
                        else          spr_lo <= mem_read_byte;
                        spr_idx <= wide && !spr_idx;
                    end
                end
                S_LOAD_SCR: begin
                    if (mem_read_ack) begin
                        old_byte  <= mem_read_byte;
                        collision <= collision | (|(mem_read_byte & pat_k));
                    end
                end
                S_STORE_SCR: k <= k_next;
                S_NEXT_ROW: begin
                    r_cnt   <= r_cnt + 5'd1;
                    row     <= row_edge ? '0 : row + RW'(1);
                    spr_idx <= 1'b0;
                    k       <= '0;
                end
                S_CLEAR: clr_cnt <= clr_cnt + CLW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_blit.sv
// Bench for gpu_blit: two instances (clip and wrap) with private memories.
// A byte-level reference model queues the expected framebuffer writes when a
// draw or clear is issued; a monitor pops and compares them as the DUT writes.
module tb_gpu_blit;

    localparam int W  = 8;
    localparam int HH = 32;
    localparam int FB = 'h100;

    typedef struct {
        int          s;
        int          a;
        logic [7:0]  d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        draw_v  [2];
    logic        clear_v [2];
    logic [11:0] addr_i;
    logic [3:0]  lines_i;
    logic [7:0]  x_i, y_i;
    logic        busy [2], done [2], coll [2], mrd [2], mwr [2], ack [2];
    logic [11:0] ridx [2], widx [2];
    logic [7:0]  rbyte [2], wbyte [2];

    logic [7:0]  mem     [2][4096];
    logic [7:0]  ref_mem [2][4096];
    logic        pre_we;
    logic [11:0] pre_a;
    logic [7:0]  pre_d;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        gpu_blit #(.ADDR_W(12), .FB_BASE(FB), .W_BYTES(W), .H(HH), .WRAP(g)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .draw           (draw_v[g]),
            .clear          (clear_v[g]),
            .addr           (addr_i),
            .lines          (lines_i),
            .x              (x_i),
            .y              (y_i),
            .busy           (busy[g]),
            .done           (done[g]),
            .collision      (coll[g]),
            .mem_read       (mrd[g]),
            .mem_read_idx   (ridx[g]),
            .mem_read_byte  (rbyte[g]),
            .mem_read_ack   (ack[g]),
            .mem_write      (mwr[g]),
            .mem_write_idx  (widx[g]),
            .mem_write_byte (wbyte[g])
        );
    end

    // Memory model: one-cycle read acknowledge, writes land on the clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) ack[i] <= 1'b0;
            else     ack[i] <= mrd[i] && !ack[i];
            rbyte[i] <= mem[i][ridx[i]];
            if (mwr[i]) mem[i][widx[i]] <= wbyte[i];
            if (pre_we) mem[i][pre_a] <= pre_d;
        end
    end

    // Write monitor: every DUT write must match the head of the expectation queue.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst && mwr[i]) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_write dut%0d got addr %h data %h, required none", i, widx[i], wbyte[i]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.s !== i || widx[i] !== 12'(mon_e.a) || wbyte[i] !== mon_e.d) begin
                        miscompares++;
                        $display("FAIL write dut%0d got addr %h data %h, required dut%0d addr %h data %h",
                                 i, widx[i], wbyte[i], mon_e.s, mon_e.a, mon_e.d);
                    end
                end
            end
        end
    end

    task automatic poke(input int a, input logic [7:0] d);
        ref_mem[0][a] = d;
        ref_mem[1][a] = d;
        @(negedge clk);
        pre_we = 1'b1; pre_a = 12'(a); pre_d = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic model_draw(input int s, input int a, input int ln, input int xx, input int yy,
                              output logic ec);
        int wide, rows, x0, y0, sh, col, nb, row, c, ad;
        logic [15:0] spr;
        logic [23:0] p;
        logic [7:0]  pb, old;
        exp_t        e;
        wide = (ln == 0);
        rows = wide ? 16 : ln;
        x0 = xx % (8 * W); y0 = yy % HH;
        sh = x0 % 8; col = x0 / 8;
        nb = (wide ? 2 : 1) + (sh != 0 ? 1 : 0);
        ec = 1'b0;
        for (int r = 0; r < rows; r++) begin
            row = y0 + r;
            if (row >= HH) begin
                if (s == 1) row = row - HH;
                else break;
            end
            if (wide) spr = {ref_mem[s][(a + 2*r) % 4096], ref_mem[s][(a + 2*r + 1) % 4096]};
            else      spr = {ref_mem[s][(a + r) % 4096], 8'h00};
            p = {spr, 8'h00} >> sh;
            for (int kk = 0; kk < nb; kk++) begin
                c = col + kk;
                if (c >= W) begin
                    if (s == 1) c = c - W;
                    else break;
                end
                ad = (FB + row * W + c) % 4096;
                pb = p[23 - 8*kk -: 8];
                old = ref_mem[s][ad];
                if ((old & pb) != 8'h00) ec = 1'b1;
                ref_mem[s][ad] = old ^ pb;
                e.s = s; e.a = ad; e.d = old ^ pb;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_op(input int s, input logic do_clear, input logic do_draw);
        @(negedge clk);
        clear_v[s] = do_clear;
        draw_v[s]  = do_draw;
        @(negedge clk);
        clear_v[s] = 1'b0;
        draw_v[s]  = 1'b0;
        vectors++;
        if (busy[s] !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_on_accept dut%0d got %b, required 1", s, busy[s]);
        end
    endtask

    task automatic wait_op(input int s, output int n);
        n = 0;
        while (busy[s] === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n >= 5000) begin
            miscompares++;
            $display("FAIL timeout dut%0d busy cycles %0d, required < 5000", s, n);
        end
        vectors++;
        if (done[s] !== 1'b1) begin
            miscompares++;
            $display("FAIL done_pulse dut%0d got %b, required 1", s, done[s]);
        end
        @(negedge clk);
        vectors++;
        if (done[s] !== 1'b0) begin
            miscompares++;
            $display("FAIL done_width dut%0d got %b, required 0", s, done[s]);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes dut%0d got %0d outstanding, required 0", s, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic draw_op(input int s, input int a, input int ln, input int xx, input int yy,
                           input int exp_busy);
        logic ec;
        int   n;
        model_draw(s, a, ln, xx, yy, ec);
        addr_i = 12'(a); lines_i = 4'(ln); x_i = 8'(xx); y_i = 8'(yy);
        start_op(s, 1'b0, 1'b1);
        wait_op(s, n);
        vectors++;
        if (coll[s] !== ec) begin
            miscompares++;
            $display("FAIL collision dut%0d a=%h x=%0d y=%0d got %b, required %b", s, a, xx, yy, coll[s], ec);
        end
        if (exp_busy >= 0) begin
            vectors++;
            if (n != exp_busy) begin
                miscompares++;
                $display("FAIL latency dut%0d got %0d cycles, required %0d", s, n, exp_busy);
            end
        end
    endtask

    task automatic clear_op(input int s);
        exp_t e;
        logic prev;
        int   n;
        prev = coll[s];
        for (int i = 0; i < W * HH; i++) begin
            ref_mem[s][FB + i] = 8'h00;
            e.s = s; e.a = FB + i; e.d = 8'h00;
            exp_q.push_back(e);
        end
        // draw raised together with clear: clear must win
        start_op(s, 1'b1, 1'b1);
        wait_op(s, n);
        vectors++;
        if (n != W * HH) begin
            miscompares++;
            $display("FAIL clear_cycles dut%0d got %0d, required %0d", s, n, W * HH);
        end
        vectors++;
        if (coll[s] !== prev) begin
            miscompares++;
            $display("FAIL clear_collision dut%0d got %b, required %b", s, coll[s], prev);
        end
    endtask

    task automatic check_mem(input string nm, input int s, input int a, input logic [7:0] d);
        vectors++;
        if (mem[s][a] !== d) begin
            miscompares++;
            $display("FAIL %s dut%0d addr %h got %h, required %h", nm, s, a, mem[s][a], d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({busy[i], done[i], coll[i], mrd[i], mwr[i]} !== 5'b0 ||
                ridx[i] !== 12'h0 || widx[i] !== 12'h0 || wbyte[i] !== 8'h0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d got busy%b done%b coll%b rd%b wr%b %h %h %h, required all 0",
                         i, busy[i], done[i], coll[i], mrd[i], mwr[i], ridx[i], widx[i], wbyte[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear();
        clear_op(0);
        clear_op(1);
    endtask

    task automatic test_aligned();
        draw_op(0, 'h000, 1, 0, 0, 6);
        check_mem("aligned_first", 0, 'h100, 8'hF0);
        draw_op(0, 'h000, 1, 0, 0, 6);
        check_mem("aligned_repeat", 0, 'h100, 8'h00);
        draw_op(0, 'h000, 1, 0, 0, -1);
        draw_op(0, 'h010, 2, 0, 0, -1);
        check_mem("two_row_r1", 0, 'h108, 8'h00);
    endtask

    task automatic test_misaligned();
        draw_op(0, 'h020, 1, 3, 2, -1);
        check_mem("misaligned_lo", 0, 'h110, 8'h1F);
        check_mem("misaligned_hi", 0, 'h111, 8'hE0);
    endtask

    task automatic test_edges();
        draw_op(0, 'h020, 1, 60, 4, -1);
        check_mem("clip_col7", 0, 'h127, 8'h0F);
        check_mem("clip_col0", 0, 'h120, 8'h00);
        draw_op(1, 'h020, 1, 60, 4, -1);
        check_mem("wrap_col7", 1, 'h127, 8'h0F);
        check_mem("wrap_col0", 1, 'h120, 8'hF0);
        draw_op(0, 'h030, 4, 8, 30, -1);
        check_mem("clip_row31", 0, 'h1F9, 8'h42);
        check_mem("clip_row0", 0, 'h101, 8'h00);
        draw_op(1, 'h030, 4, 8, 30, -1);
        check_mem("wrap_row0", 1, 'h101, 8'h24);
        check_mem("wrap_row1", 1, 'h109, 8'h18);
    endtask

    task automatic test_wide();
        draw_op(0, 'h040, 0, 4, 5, -1);
        draw_op(1, 'h040, 0, 60, 20, -1);
        draw_op(0, 'h040, 0, 124, 200, -1);
    endtask

    task automatic test_back_to_back();
        int s, a;
        for (int t = 0; t < 8; t++) begin
            s = int'($urandom_range(0, 1));
            a = 16 * int'($urandom_range(0, 4));
            draw_op(s, a, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), -1);
        end
        clear_op(0);
    endtask

    task automatic test_reset_mid();
        logic ec;
        model_draw(0, 'h040, 0, 4, 9, ec);
        addr_i = 12'h040; lines_i = 4'd0; x_i = 8'd4; y_i = 8'd9;
        start_op(0, 1'b0, 1'b1);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (busy[0] !== 1'b0 || mrd[0] !== 1'b0 || mwr[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort got busy%b rd%b wr%b, required 000", busy[0], mrd[0], mwr[0]);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W * HH; i++) ref_mem[0][FB + i] = mem[0][FB + i];
        @(negedge clk);
        clear_op(0);
        draw_op(0, 'h000, 1, 0, 0, 6);
    endtask

    initial begin
        draw_v[0] = 1'b0; draw_v[1] = 1'b0;
        clear_v[0] = 1'b0; clear_v[1] = 1'b0;
        addr_i = '0; lines_i = '0; x_i = '0; y_i = '0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        test_reset();
        for (int i = 0; i < 'h80; i++) poke(i, 8'($urandom));
        poke('h000, 8'hF0);
        poke('h010, 8'hF0); poke('h011, 8'h00);
        poke('h020, 8'hFF);
        poke('h030, 8'h81); poke('h031, 8'h42); poke('h032, 8'h24); poke('h033, 8'h18);
        test_clear();
        test_aligned();
        test_misaligned();
        test_edges();
        test_wide();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
